// File: rtl/clarvi_pio_pwm.sv
// Parametrised LED/button PIO for clarvi_soc: Avalon-MM slave, per-channel PWM, debounced buttons with edge IRQ.
// Optional blink engine (addresses 5/6) is built only when CLARVI_PIO_BLINK_EN is defined.
module clarvi_pio_pwm #(
    parameter int N_LED           = 8,
    parameter int N_BTN           = 1,
    parameter int PWM_BITS        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BTN_INVERT      = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [4:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [N_LED-1:0]  led,
    input  logic [N_BTN-1:0]  btn,
    output logic              irq
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [N_LED-1:0]    led_out, pwm_en, led_next, wr_duty;
    logic [N_BTN-1:0]    edge_cap, irq_mask, btn_state, btn_in, sync1, sync2;
    logic [N_BTN-1:0]    db_flip, rise, w1c;
    logic [DB_W-1:0]     db_cnt [N_BTN];
    logic [PWM_BITS-1:0] duty_stage [N_LED];
    logic [PWM_BITS-1:0] duty_act [N_LED];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [31:0]         rd_data;
    logic                unused_wdata;

    assign unused_wdata = ^avs_writedata;
    assign btn_in = (BTN_INVERT != 0) ? ~btn : btn;
    assign w1c = (avs_write && avs_address == 5'd3) ? avs_writedata[N_BTN-1:0] : '0;

    always_comb begin
        wr_duty = '0;
        for (int i = 0; i < N_LED; i++)
            wr_duty[i] = avs_write && (avs_address == 5'(16 + i));
    end

    always_comb begin
        db_flip = '0;
        for (int j = 0; j < N_BTN; j++)
            db_flip[j] = (sync2[j] != btn_state[j]) && (db_cnt[j] == DB_LAST);
    end
    assign rise = db_flip & sync2;

`ifdef CLARVI_PIO_BLINK_EN
    logic [N_LED-1:0] blink_mask;
    logic [31:0]      blink_reload, blink_cnt;
    logic             blink_phase;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            blink_mask   <= '0;
            blink_reload <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else begin
            if (avs_write && avs_address == 5'd5)
                blink_mask <= avs_writedata[N_LED-1:0];
            // A reload write restarts the period from a known "off" phase
            if (avs_write && avs_address == 5'd6) begin
                blink_reload <= avs_writedata;
                blink_cnt    <= avs_writedata;
                blink_phase  <= 1'b0;
            end else if (blink_cnt == 32'd0) begin
                blink_cnt   <= blink_reload;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt - 32'd1;
            end
        end
    end
`endif

    always_comb begin
        led_next = '0;
        for (int i = 0; i < N_LED; i++) begin
            led_next[i] = led_out[i] & (~pwm_en[i] | (pwm_cnt < duty_act[i]));
`ifdef CLARVI_PIO_BLINK_EN
            led_next[i] = led_next[i] & (~blink_mask[i] | blink_phase);
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        case (avs_address)
            5'd0: rd_data[N_LED-1:0] = led_out;
            5'd1: rd_data[N_LED-1:0] = pwm_en;
            5'd2: rd_data[N_BTN-1:0] = btn_state;
            5'd3: rd_data[N_BTN-1:0] = edge_cap;
            5'd4: rd_data[N_BTN-1:0] = irq_mask;
`ifdef CLARVI_PIO_BLINK_EN
            5'd5: rd_data[N_LED-1:0] = blink_mask;
            5'd6: rd_data = blink_reload;
`endif
            default: begin
                for (int i = 0; i < N_LED; i++)
                    if (avs_address == 5'(16 + i))
                        rd_data[PWM_BITS-1:0] = duty_stage[i];
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led_out           <= '0;
            pwm_en            <= '0;
            irq_mask          <= '0;
            edge_cap          <= '0;
            btn_state         <= '0;
            sync1             <= '0;
            sync2             <= '0;
            pwm_cnt           <= '0;
            led               <= '0;
            irq               <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            for (int i = 0; i < N_LED; i++) begin
                duty_stage[i] <= '0;
                duty_act[i]   <= '0;
            end
            for (int j = 0; j < N_BTN; j++)
                db_cnt[j] <= '0;
        end else begin
            if (avs_write && avs_address == 5'd0) led_out  <= avs_writedata[N_LED-1:0];
            if (avs_write && avs_address == 5'd1) pwm_en   <= avs_writedata[N_LED-1:0];
            if (avs_write && avs_address == 5'd4) irq_mask <= avs_writedata[N_BTN-1:0];

            // Active duty only changes at the period boundary, so no mid-period glitch
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int i = 0; i < N_LED; i++) begin
                if (wr_duty[i]) duty_stage[i] <= avs_writedata[PWM_BITS-1:0];
                if (&pwm_cnt)   duty_act[i]   <= duty_stage[i];
            end
            led <= led_next;

            sync1 <= btn_in;
            sync2 <= sync1;
            for (int j = 0; j < N_BTN; j++) begin
                if (sync2[j] == btn_state[j]) begin
                    db_cnt[j] <= '0;
                end else if (db_flip[j]) begin
                    btn_state[j] <= sync2[j];
                    db_cnt[j]    <= '0;
                end else begin
                    db_cnt[j] <= db_cnt[j] + 1'b1;
                end
            end

            // A new press outranks a simultaneous clear
            edge_cap <= (edge_cap & ~w1c) | rise;
            irq      <= |(edge_cap & irq_mask);

            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_data;
        end
    end
endmodule

// File: doc/clarvi_pio_pwm.md
Name: clarvi_pio_pwm

Overview:
- Parametrised successor to the fixed 8-bit LED PIO behind the clarvi_soc Avalon bus.
- Drives N_LED outputs, each with a direct on/off bit and optional per-channel PWM brightness.
- Samples N_BTN asynchronous push-buttons through a synchroniser and debouncer, with edge capture and a maskable interrupt.
- Sits as an Avalon-MM slave in clarvi_soc; its outputs and inputs go straight to board pins.

Parameters:
- N_LED, 8, LED channel count (1..16).
- N_BTN, 1, button input count (1..16).
- PWM_BITS, 8, PWM counter and duty width (2..16).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed before a button change is accepted (1 ms at 50 MHz); must be at least 1.
- BTN_INVERT, 1, when 1 the raw pins are active-low and are inverted before the synchroniser.

Ports:
- clk_clk  in  1  system clock (50 MHz from PLL).
- reset_reset  in  1  asynchronous, active-high reset.
- avs_address  in  5  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  high for exactly one cycle with each read response.
- led  out  N_LED  LED drive, active-high.
- btn  in  N_BTN  raw asynchronous button pins.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async assert):
  - All registers, counters, led, irq, avs_readdata and avs_readdatavalid go to 0.
  - Debounced state is "not pressed".
  - Synchroniser flops are cleared.
  - Reset may assert at any time; there is no partial state after release.
- Register map (word addresses). Bits above the channel width read 0 and ignore writes.
  - 0 LED_OUT, RW, N_LED bits.
  - 1 PWM_EN, RW, N_LED bits.
  - 2 BTN_STATE, RO, debounced state, 1 = pressed.
  - 3 EDGE_CAP, RW1C.
  - 4 IRQ_MASK, RW.
  - 16+i DUTY[i], RW, PWM_BITS bits, for i < N_LED.
  - Unmapped addresses read 0 and ignore writes.
- Bus:
  - Read latency is fixed at 1: avs_readdata is registered and avs_readdatavalid is asserted the cycle after avs_read.
  - Writes complete in the cycle they are presented; there is no waitrequest.
  - Simultaneous read and write to the same address returns the old value.
- PWM:
  - Free-running PWM_BITS counter, incrementing every cycle and wrapping to 0.
  - Each DUTY write goes to a staging register. The active duty copies from staging only in the cycle the counter equals all-ones, so duty changes never glitch mid-period.
  - Channel output:
    - led[i] = LED_OUT[i] & (cnt < duty_active[i]) when PWM_EN[i] = 1.
    - led[i] = LED_OUT[i] otherwise.
  - duty 0 gives always off; duty 2^PWM_BITS-1 gives on for all but one cycle per period.
  - led is registered, so output lags the register write by 1 cycle.
- Debounce, per button:
  - Pin goes through BTN_INVERT, then a 2-flop synchroniser.
  - A counter increments while the synchronised value differs from the debounced state and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the state flips and the counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES cycles is rejected.
  - The counter saturates; it never wraps.
- Edge capture and interrupt:
  - EDGE_CAP[j] sets on a 0 to 1 transition of debounced state j.
  - Writing 1 clears a bit. A set event in the same cycle as a W1C clear wins, so the bit stays 1.
  - irq = |(EDGE_CAP & IRQ_MASK), registered with 1-cycle latency.

Optional Feature:
- Macro: CLARVI_PIO_BLINK_EN.
- With the macro defined:
  - Address 5 is BLINK_MASK (RW, N_LED bits).
  - Address 6 is BLINK_RELOAD (RW, 32 bits).
  - A 32-bit down-counter loads BLINK_RELOAD and decrements each cycle. On reaching 0 it toggles a phase bit and reloads.
  - Channels with BLINK_MASK[i] = 1 are additionally ANDed with the phase bit, after the PWM gating.
  - A write to BLINK_RELOAD immediately reloads the counter and clears the phase bit.
- Without the macro: addresses 5 and 6 behave as unmapped, and no blink logic is synthesised.

Test Plan:
- Write LED_OUT = 0xA5 with PWM_EN = 0 -> led = 0xA5 one cycle after the write; read of address 0 returns 0x000000A5 with avs_readdatavalid 1 cycle after avs_read.
- PWM_BITS = 8, PWM_EN = 0x01, LED_OUT = 0x01, DUTY[0] = 64 -> led[0] is high for exactly 64 of every 256 cycles. Changing DUTY[0] to 192 mid-period takes effect only from the next counter wrap.
- DEBOUNCE_CYCLES = 16, btn pulsed low (pressed) for 10 cycles -> BTN_STATE stays 0 and EDGE_CAP stays 0. Held low for 20 cycles -> BTN_STATE = 1 exactly 2+16 cycles after the pin falls, EDGE_CAP[0] = 1.
- IRQ_MASK = 1 with EDGE_CAP[0] set -> irq = 1. Write 1 to EDGE_CAP -> irq = 0. A W1C coinciding with a new press edge -> EDGE_CAP[0] stays 1 and irq stays 1.
- Assert reset_reset mid-PWM period and mid-debounce -> led, irq and all registers read 0 immediately. After release, a stable press again needs the full DEBOUNCE_CYCLES.
- With CLARVI_PIO_BLINK_EN: BLINK_RELOAD = 3, BLINK_MASK = 0x01, LED_OUT = 0x01 -> led[0] toggles every 4 cycles. Without the macro: read of address 6 returns 0.
